// File: rtl/multicycle_ctrl.sv
// Multicycle processor control FSM: FETCH/DECODE/EXEC/MEM/WB sequencing with
// combinational datapath strobes, a retired-instruction counter and a memory-wait watchdog.
module multicycle_ctrl #(
   parameter int CNT_W       = 16,
   parameter int MEM_TIMEOUT = 255
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [5:0]       Opcode,
   input  logic             Zero,
   input  logic             MemReady,
   output logic             ALUSrc,
   output logic [1:0]       ALUOp,
   output logic             RegDst,
   output logic             RegWrite,
   output logic             MemtoReg,
   output logic             MemRead,
   output logic             MemWrite,
   output logic             IRWrite,
   output logic             PCWrite,
   output logic [2:0]       State,
   output logic [CNT_W-1:0] InstrCount,
   output logic             Illegal,
   output logic             Fault
);

   typedef enum logic [2:0] {
      FETCH  = 3'd0,
      DECODE = 3'd1,
      EXEC   = 3'd2,
      MEM    = 3'd3,
      WB     = 3'd4
   } state_t;

   localparam logic [5:0] OP_R    = 6'b000000;
   localparam logic [5:0] OP_LW   = 6'b100011;
   localparam logic [5:0] OP_SW   = 6'b101011;
   localparam logic [5:0] OP_BEQ  = 6'b000100;
   localparam logic [5:0] OP_ADDI = 6'b001000;
   localparam logic [5:0] OP_J    = 6'b000010;

   localparam int WAIT_W = (MEM_TIMEOUT < 1) ? 1 : $clog2(MEM_TIMEOUT + 1);

   state_t            state;
   state_t            nxt;
   logic [WAIT_W-1:0] wait_cnt;
   logic              retire;
   logic              mem_phase;
   logic              timeout;
   logic              enter;

   assign State     = state;
   assign mem_phase = (state == FETCH) || (state == MEM);
   assign timeout   = mem_phase && (wait_cnt == WAIT_W'(MEM_TIMEOUT));
   // A timeout re-enters FETCH from FETCH, which must still restart the wait count.
   assign enter     = ((nxt == FETCH) || (nxt == MEM)) && ((nxt != state) || timeout);

   always_comb begin
      nxt      = state;
      retire   = 1'b0;
      ALUSrc   = 1'b0;
      ALUOp    = 2'b00;
      RegDst   = 1'b0;
      RegWrite = 1'b0;
      MemtoReg = 1'b0;
      MemRead  = 1'b0;
      MemWrite = 1'b0;
      IRWrite  = 1'b0;
      PCWrite  = 1'b0;
      Illegal  = 1'b0;
      case (state)
         FETCH: begin
            if (timeout) begin
               nxt = FETCH;
            end else begin
               MemRead = 1'b1;
               if (MemReady) begin
                  IRWrite = 1'b1;
                  PCWrite = 1'b1;
                  nxt     = DECODE;
               end
            end
         end
         DECODE: begin
            case (Opcode)
               OP_J: begin
                  PCWrite = 1'b1;
                  retire  = 1'b1;
                  nxt     = FETCH;
               end
               OP_R, OP_LW, OP_SW, OP_BEQ, OP_ADDI: nxt = EXEC;
               default: begin
                  Illegal = 1'b1;
                  nxt     = FETCH;
               end
            endcase
         end
         EXEC: begin
            case (Opcode)
               OP_LW, OP_SW: begin
                  ALUSrc = 1'b1;
                  nxt    = MEM;
               end
               OP_ADDI: begin
                  ALUSrc = 1'b1;
                  nxt    = WB;
               end
               OP_R: begin
                  ALUOp = 2'b10;
                  nxt   = WB;
               end
               OP_BEQ: begin
                  ALUOp   = 2'b01;
                  PCWrite = Zero;
                  retire  = 1'b1;
                  nxt     = FETCH;
               end
               default: nxt = FETCH;
            endcase
         end
         MEM: begin
            if (timeout) begin
               nxt = FETCH;
            end else begin
               MemRead  = (Opcode == OP_LW);
               MemWrite = (Opcode == OP_SW);
               if (MemReady) begin
                  if (Opcode == OP_LW) begin
                     nxt = WB;
                  end else begin
                     retire = (Opcode == OP_SW);
                     nxt    = FETCH;
                  end
               end
            end
         end
         WB: begin
            RegWrite = 1'b1;
            RegDst   = (Opcode == OP_R);
            MemtoReg = (Opcode == OP_LW);
            retire   = 1'b1;
            nxt      = FETCH;
         end
         default: nxt = FETCH;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state      <= FETCH;
         InstrCount <= '0;
         Fault      <= 1'b0;
         wait_cnt   <= '0;
      end else begin
         state <= nxt;
         if (retire) InstrCount <= InstrCount + 1'b1;
         if (timeout) Fault <= 1'b1;
         if (enter) begin
            wait_cnt <= '0;
         end else if (mem_phase && !MemReady) begin
            wait_cnt <= wait_cnt + 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Scoreboard bench for multicycle_ctrl: the driver queues hand-tabulated per-cycle
// expectations and a negedge monitor pops and compares them against the DUT outputs.
module tb_multicycle_ctrl;

   localparam logic [5:0] OP_R    = 6'b000000;
   localparam logic [5:0] OP_LW   = 6'b100011;
   localparam logic [5:0] OP_SW   = 6'b101011;
   localparam logic [5:0] OP_BEQ  = 6'b000100;
   localparam logic [5:0] OP_ADDI = 6'b001000;
   localparam logic [5:0] OP_J    = 6'b000010;
   localparam logic [5:0] OP_BAD  = 6'b111111;

   localparam logic [2:0] S_FETCH  = 3'd0;
   localparam logic [2:0] S_DECODE = 3'd1;
   localparam logic [2:0] S_EXEC   = 3'd2;
   localparam logic [2:0] S_MEM    = 3'd3;
   localparam logic [2:0] S_WB     = 3'd4;

   // strobe byte: {ALUSrc, RegDst, RegWrite, MemtoReg, MemRead, MemWrite, IRWrite, PCWrite}
   typedef struct packed {
      logic [2:0] st;
      logic [7:0] sb;
      logic [1:0] ao;
      logic       ill;
      logic       flt;
      logic [3:0] cnt;
   } exp_t;

   logic       clk;
   logic       reset;
   logic [5:0] Opcode;
   logic       Zero;
   logic       MemReady;
   logic       ALUSrc;
   logic [1:0] ALUOp;
   logic       RegDst;
   logic       RegWrite;
   logic       MemtoReg;
   logic       MemRead;
   logic       MemWrite;
   logic       IRWrite;
   logic       PCWrite;
   logic [2:0] State;
   logic [3:0] InstrCount;
   logic       Illegal;
   logic       Fault;

   exp_t       exp_q[$];
   int         total;
   int         bad;
   logic [3:0] ecnt;
   logic       efault;

   multicycle_ctrl #(.CNT_W(4), .MEM_TIMEOUT(4)) dut (
      .clk(clk), .reset(reset), .Opcode(Opcode), .Zero(Zero), .MemReady(MemReady),
      .ALUSrc(ALUSrc), .ALUOp(ALUOp), .RegDst(RegDst), .RegWrite(RegWrite),
      .MemtoReg(MemtoReg), .MemRead(MemRead), .MemWrite(MemWrite), .IRWrite(IRWrite),
      .PCWrite(PCWrite), .State(State), .InstrCount(InstrCount), .Illegal(Illegal),
      .Fault(Fault)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(negedge clk) begin
      exp_t e;
      exp_t a;
      if (exp_q.size() > 0) begin
         e     = exp_q.pop_front();
         a.st  = State;
         a.sb  = {ALUSrc, RegDst, RegWrite, MemtoReg, MemRead, MemWrite, IRWrite, PCWrite};
         a.ao  = ALUOp;
         a.ill = Illegal;
         a.flt = Fault;
         a.cnt = InstrCount;
         total++;
         if (a !== e) begin
            bad++;
            $display("FAIL ctrl_vec #%0d: got st=%0d sb=%b ao=%b ill=%b flt=%b cnt=%0d, want st=%0d sb=%b ao=%b ill=%b flt=%b cnt=%0d",
                     total, a.st, a.sb, a.ao, a.ill, a.flt, a.cnt,
                     e.st, e.sb, e.ao, e.ill, e.flt, e.cnt);
         end
      end
   end

   task automatic step(input logic [5:0] op, input logic z, input logic rdy,
                       input logic [2:0] st, input logic [7:0] sb, input logic [1:0] ao,
                       input logic ill);
      exp_t e;
      Opcode   = op;
      Zero     = z;
      MemReady = rdy;
      e.st  = st;
      e.sb  = sb;
      e.ao  = ao;
      e.ill = ill;
      e.flt = efault;
      e.cnt = ecnt;
      exp_q.push_back(e);
      @(posedge clk);
      #1;
   endtask

   // One instruction with MemReady tied high, cycle by cycle as tabulated by hand.
   task automatic instr(input logic [5:0] op, input logic z);
      step(op, z, 1'b1, S_FETCH, 8'b0000_1011, 2'b00, 1'b0);
      case (op)
         OP_LW: begin
            step(op, z, 1'b1, S_DECODE, 8'b0000_0000, 2'b00, 1'b0);
            step(op, z, 1'b1, S_EXEC,   8'b1000_0000, 2'b00, 1'b0);
            step(op, z, 1'b1, S_MEM,    8'b0000_1000, 2'b00, 1'b0);
            step(op, z, 1'b1, S_WB,     8'b0011_0000, 2'b00, 1'b0);
         end
         OP_SW: begin
            step(op, z, 1'b1, S_DECODE, 8'b0000_0000, 2'b00, 1'b0);
            step(op, z, 1'b1, S_EXEC,   8'b1000_0000, 2'b00, 1'b0);
            step(op, z, 1'b1, S_MEM,    8'b0000_0100, 2'b00, 1'b0);
         end
         OP_R: begin
            step(op, z, 1'b1, S_DECODE, 8'b0000_0000, 2'b00, 1'b0);
            step(op, z, 1'b1, S_EXEC,   8'b0000_0000, 2'b10, 1'b0);
            step(op, z, 1'b1, S_WB,     8'b0110_0000, 2'b00, 1'b0);
         end
         OP_ADDI: begin
            step(op, z, 1'b1, S_DECODE, 8'b0000_0000, 2'b00, 1'b0);
            step(op, z, 1'b1, S_EXEC,   8'b1000_0000, 2'b00, 1'b0);
            step(op, z, 1'b1, S_WB,     8'b0010_0000, 2'b00, 1'b0);
         end
         OP_BEQ: begin
            step(op, z, 1'b1, S_DECODE, 8'b0000_0000, 2'b00, 1'b0);
            step(op, z, 1'b1, S_EXEC,   {7'b0, z},    2'b01, 1'b0);
         end
         OP_J: begin
            step(op, z, 1'b1, S_DECODE, 8'b0000_0001, 2'b00, 1'b0);
         end
         default: begin
            step(op, z, 1'b1, S_DECODE, 8'b0000_0000, 2'b00, 1'b1);
         end
      endcase
      if (op == OP_LW || op == OP_SW || op == OP_R || op == OP_ADDI ||
          op == OP_BEQ || op == OP_J) ecnt = ecnt + 4'd1;
   endtask

   initial begin
      total    = 0;
      bad      = 0;
      ecnt     = 4'd0;
      efault   = 1'b0;
      reset    = 1'b1;
      Opcode   = OP_R;
      Zero     = 1'b0;
      MemReady = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      reset = 1'b0;

      // Post-reset FETCH waiting on memory, then the full instruction mix.
      step(OP_LW, 1'b0, 1'b0, S_FETCH, 8'b0000_1000, 2'b00, 1'b0);
      step(OP_LW, 1'b0, 1'b0, S_FETCH, 8'b0000_1000, 2'b00, 1'b0);
      instr(OP_LW, 1'b0);
      instr(OP_SW, 1'b0);
      instr(OP_R, 1'b0);
      instr(OP_ADDI, 1'b0);
      instr(OP_BEQ, 1'b1);
      instr(OP_J, 1'b0);
      instr(OP_BEQ, 1'b0);
      instr(OP_BAD, 1'b0);

      // LW stalled three cycles in MEM.
      step(OP_LW, 1'b0, 1'b1, S_FETCH,  8'b0000_1011, 2'b00, 1'b0);
      step(OP_LW, 1'b0, 1'b1, S_DECODE, 8'b0000_0000, 2'b00, 1'b0);
      step(OP_LW, 1'b0, 1'b1, S_EXEC,   8'b1000_0000, 2'b00, 1'b0);
      for (int i = 0; i < 3; i++)
         step(OP_LW, 1'b0, 1'b0, S_MEM, 8'b0000_1000, 2'b00, 1'b0);
      step(OP_LW, 1'b0, 1'b1, S_MEM,    8'b0000_1000, 2'b00, 1'b0);
      step(OP_LW, 1'b0, 1'b1, S_WB,     8'b0011_0000, 2'b00, 1'b0);
      ecnt = ecnt + 4'd1;

      // R with MemReady low outside the memory states must not stall.
      step(OP_R, 1'b0, 1'b1, S_FETCH,  8'b0000_1011, 2'b00, 1'b0);
      step(OP_R, 1'b0, 1'b0, S_DECODE, 8'b0000_0000, 2'b00, 1'b0);
      step(OP_R, 1'b0, 1'b0, S_EXEC,   8'b0000_0000, 2'b10, 1'b0);
      step(OP_R, 1'b0, 1'b0, S_WB,     8'b0110_0000, 2'b00, 1'b0);
      ecnt = ecnt + 4'd1;

      // Reset in EXEC abandons the instruction and clears the count.
      step(OP_R, 1'b0, 1'b1, S_FETCH,  8'b0000_1011, 2'b00, 1'b0);
      step(OP_R, 1'b0, 1'b1, S_DECODE, 8'b0000_0000, 2'b00, 1'b0);
      reset = 1'b1;
      step(OP_R, 1'b0, 1'b1, S_EXEC,   8'b0000_0000, 2'b10, 1'b0);
      reset = 1'b0;
      ecnt  = 4'd0;

      // 17 retires on a 4-bit counter wrap through zero to one.
      for (int i = 0; i < 17; i++) instr(OP_J, 1'b0);
      step(OP_SW, 1'b0, 1'b0, S_FETCH, 8'b0000_1000, 2'b00, 1'b0);
      step(OP_SW, 1'b0, 1'b1, S_FETCH, 8'b0000_1011, 2'b00, 1'b0);
      step(OP_SW, 1'b0, 1'b1, S_DECODE, 8'b0000_0000, 2'b00, 1'b0);
      step(OP_SW, 1'b0, 1'b1, S_EXEC,   8'b1000_0000, 2'b00, 1'b0);
      step(OP_SW, 1'b0, 1'b1, S_MEM,    8'b0000_0100, 2'b00, 1'b0);
      ecnt = ecnt + 4'd1;

      // FETCH starved of MemReady: four wait cycles, then the timeout cycle.
      for (int i = 0; i < 4; i++)
         step(OP_J, 1'b0, 1'b0, S_FETCH, 8'b0000_1000, 2'b00, 1'b0);
      step(OP_J, 1'b0, 1'b0, S_FETCH, 8'b0000_0000, 2'b00, 1'b0);
      efault = 1'b1;
      step(OP_J, 1'b0, 1'b0, S_FETCH, 8'b0000_1000, 2'b00, 1'b0);
      instr(OP_J, 1'b0);
      instr(OP_ADDI, 1'b0);

      // Only reset clears the sticky fault.
      reset = 1'b1;
      step(OP_J, 1'b0, 1'b0, S_FETCH, 8'b0000_1000, 2'b00, 1'b0);
      reset  = 1'b0;
      efault = 1'b0;
      ecnt   = 4'd0;
      step(OP_J, 1'b0, 1'b0, S_FETCH, 8'b0000_1000, 2'b00, 1'b0);
      instr(OP_J, 1'b0);
      step(OP_J, 1'b0, 1'b0, S_FETCH, 8'b0000_1000, 2'b00, 1'b0);

      repeat (2) @(posedge clk);
      if (exp_q.size() != 0) begin
         bad++;
         $display("FAIL drain: pending=%0d want=0", exp_q.size());
      end
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: time=%0t limit=200000", $time);
      $fatal(1, "watchdog expired");
   end

endmodule
